// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline handshake/flush sequencer
package pipe_pkg;

   // Outstanding-fetch counters are sized for the largest legal MAX_OUT (7).
   localparam int MAX_OUT_LIMIT = 7;
   localparam int OUT_W = $clog2(MAX_OUT_LIMIT + 1);

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } drain_state_t;

   typedef struct packed {
      logic d;
      logic e;
      logic m;
      logic w;
   } stage_vld_t;

endpackage

// File: rtl/pipe_ctrl_fetch_drop_tracker.sv
// rtl/pipe_ctrl_fetch_drop_tracker.sv - outstanding fetch count and wrong-path response drain FSM
module fetch_drop_tracker
   import pipe_pkg::*;
#(
   parameter int MAX_OUT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic if_gnt,
   input  logic if_rsp_valid,
   input  logic ready_D,
   input  logic redir_fire,
   output logic if_req,
   output logic if_rsp_ready,
   output logic drop_rsp
);

   logic [OUT_W-1:0] outst;
   logic [OUT_W-1:0] outst_nxt;
   logic [OUT_W-1:0] drop_cnt;
   logic [OUT_W-1:0] drop_cnt_nxt;
   drain_state_t     state;
   drain_state_t     state_nxt;
   logic             grant;
   logic             consume;

   assign if_req       = (outst < OUT_W'(MAX_OUT));
   assign if_rsp_ready = drop_rsp | ready_D;
   assign grant        = if_req & if_gnt;
   assign consume      = if_rsp_valid & if_rsp_ready;
   assign outst_nxt    = outst + OUT_W'(grant) - OUT_W'(consume);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outst <= '0;
      end else begin
         outst <= outst_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         drop_cnt <= '0;
      end else begin
         state    <= state_nxt;
         drop_cnt <= drop_cnt_nxt;
      end
   end

   // A request granted alongside the redirect already carries the target PC,
   // so only requests still in flight after this cycle's response are stale.
   always_comb begin
      state_nxt    = state;
      drop_cnt_nxt = drop_cnt;
      if (redir_fire) begin
         drop_cnt_nxt = outst - OUT_W'(consume);
         state_nxt    = (drop_cnt_nxt != '0) ? DRAIN : RUN;
      end else if (state == DRAIN && if_rsp_valid) begin
         drop_cnt_nxt = drop_cnt - 1'b1;
         state_nxt    = (drop_cnt_nxt == '0) ? RUN : DRAIN;
      end
   end

   always_comb begin
      drop_rsp = 1'b0;
      if (state == DRAIN) begin
         drop_rsp = 1'b1;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stage valid/ready/enable sequencing and redirect flush for the 5-stage pipeline
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int MAX_OUT = 2,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             if_req,
   input  logic             if_gnt,
   input  logic             if_rsp_valid,
   output logic             if_rsp_ready,
   output logic             drop_rsp,
   input  logic             stall_D,
   input  logic             ex_busy_E,
   input  logic             redirect_E,
   input  logic             mem_busy_M,
   output logic             pc_sel,
   output logic             valid_D,
   output logic             valid_E,
   output logic             valid_M,
   output logic             valid_W,
   output logic             ready_E,
   output logic             ready_M,
   output logic             ready_W,
   output logic             en_D,
   output logic             en_E,
   output logic             en_M,
   output logic             en_W,
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_flush_cnt
);

   stage_vld_t vld;
   logic       ready_D;
   logic       redir_fire;
   logic       stall_ev;

   assign ready_W = 1'b1;
   assign ready_M = ~(vld.m & mem_busy_M);
   assign ready_E = ready_M & ~(vld.e & ex_busy_E);
   assign ready_D = ready_E & ~(vld.d & stall_D);

   assign en_W = vld.m & ready_M;
   assign en_M = ready_M;
   assign en_E = ready_E;
   assign en_D = ready_D;

   // Redirect only fires once E actually advances, so a busy M or E defers it.
   assign redir_fire = vld.e & redirect_E & ready_E;
   assign pc_sel     = redir_fire;
   assign stall_ev   = vld.d & ~ready_D;

   assign valid_D = vld.d;
   assign valid_E = vld.e;
   assign valid_M = vld.m;
   assign valid_W = vld.w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
      end else begin
         vld.w <= vld.m & ready_M;
         if (ready_M) begin
            vld.m <= vld.e & ready_E;
         end
         if (ready_E) begin
            vld.e <= vld.d & ~stall_D & ~redir_fire;
         end
         if (redir_fire) begin
            vld.d <= 1'b0;
         end else if (ready_D) begin
            vld.d <= if_rsp_valid & ~drop_rsp;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (stall_ev && perf_stall_cnt != '1) begin
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
         end
         if (redir_fire && perf_flush_cnt != '1) begin
            perf_flush_cnt <= perf_flush_cnt + 1'b1;
         end
      end
   end

   fetch_drop_tracker #(
      .MAX_OUT (MAX_OUT)
   ) u_fetch_drop_tracker (
      .clk          (clk),
      .rst          (rst),
      .if_gnt       (if_gnt),
      .if_rsp_valid (if_rsp_valid),
      .ready_D      (ready_D),
      .redir_fire   (redir_fire),
      .if_req       (if_req),
      .if_rsp_ready (if_rsp_ready),
      .drop_rsp     (drop_rsp)
   );

endmodule
